vga_frame_reader: RTL and testbench
===================================

# vga_frame_reader

Display-side reader for the video framebuffer that the CPU's `VGA` instruction writes. Generates 640x480@60 Hz VGA timing at one pixel per clock and scans the framebuffer in raster order. Each framebuffer cell is enlarged to a square block of pixels, and the cell colour is driven onto the RGB pins. Sits between the framebuffer's read port and the board VGA connector.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- CELL_SIZE, 10, pixels per cell edge (horizontal and vertical)
- COL_BITS, 6, column field width of the framebuffer address
- ROW_BITS, 6, row field width of the framebuffer address

Ports:
- Clock  in  1  pixel clock (25 MHz nominal); one clock, all logic on rising edge
- Reset  in  1  asynchronous, active-low reset
- oReadAddress  out  ROW_BITS+COL_BITS  framebuffer read address, {row, col}
- iReadData  in  3  framebuffer cell colour; data is valid one clock after the address
- oVGA_R  out  1  red
- oVGA_G  out  1  green
- oVGA_B  out  1  blue
- oVGA_HS  out  1  horizontal sync, active low
- oVGA_VS  out  1  vertical sync, active low
- oFrameStart  out  1  one-clock pulse aligned with the first visible output pixel of each frame

## Operation
- hcount: 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters (800). It wraps to 0 and advances vcount.
- vcount: 0..V_TOTAL-1, where V_TOTAL = sum of the V_* parameters (525). It wraps to 0.
- Horizontal phase decoded from hcount, in order: VISIBLE [0,640), FRONT [640,656), SYNC [656,752), BACK [752,800).
- Vertical phase decoded the same way from vcount: VISIBLE [0,480), FRONT [480,490), SYNC [490,492), BACK [492,525).
- Cell scan uses sub-counters only, with no dividers:
  - hsub counts 0..CELL_SIZE-1. It increments col when it wraps.
  - hsub and col clear at hcount = H_TOTAL-1.
  - vsub and row advance once per line, at the end of the line.
  - vsub, row, hsub and col all clear at the end of the frame.
- Framebuffer layout:
  - Default geometry is 64 cols x 48 rows, of which 64 cols x 48 rows are visible.
  - Cell (row, col) lives at address {row, col}.
  - The addressed region covers 4096 entries.
- oReadAddress = {row, col} during visible region. Holds its last value outside it.
- Colour mapping: iReadData[2] drives R, [1] drives G, [0] drives B. 3'b010 (green) gives G only.
- RGB is forced to 0 whenever the pixel in the aligned pipeline stage is outside the visible region.
- Sync levels: HS low iff horizontal phase is SYNC. VS low iff vertical phase is SYNC. HS is generated on every line, including during vertical blanking.

## Timing
- Pipeline depth is 2 clocks from counter to pins:
  - stage 1 registers the address;
  - stage 2 registers the RAM data and the delayed HS, VS and visible flags.
- HS, VS, visible and oFrameStart are delayed by the same 2 stages, so sync and colour stay pixel-aligned.
- Pixel (h, v) from the counters appears on the pins 2 clocks after hcount = h, vcount = v.
- Reset values (asynchronous on Reset low):
  - hcount, vcount, hsub, vsub, col, row = 0
  - oReadAddress = 0
  - oVGA_R, oVGA_G, oVGA_B = 0
  - oVGA_HS = 1, oVGA_VS = 1
  - oFrameStart = 0
  - all pipeline stages cleared to "not visible, sync inactive"
- On Reset release, hcount = 0, vcount = 0 on the first rising edge. The first visible pixel reaches the pins 2 clocks later, with oFrameStart = 1.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronous). No partial line is completed.
- Frame period = 420000 clocks. Line period = 800 clocks.
- Simultaneous hcount and vcount wrap at (799, 524): every counter returns to 0 on the same edge.
- The framebuffer write port is not this block's concern. Writes landing mid-scan show up on the next read of that cell.

## Structure
- The shared definitions header carries:
  - the default timing constants;
  - the colour encodings (COLOR_BLACK 3'b000, COLOR_BLUE 3'b001, COLOR_GREEN 3'b010, COLOR_RED 3'b100, COLOR_MAGENTA 3'b101);
  - the RGB bit positions.
- One sub-module: `vga_timing_counter`.
  - Parameterised on total and the sync window.
  - Outputs count, sync level, visible flag and wrap pulse.
  - Instantiated twice: horizontal, and vertical with an enable from the horizontal wrap pulse.
- The cell sub-counters and the 2-stage pipeline live in the top module.

## Test plan
- Reset release, framebuffer all 3'b010:
  - clock 2 after release → RGB = 010 and oFrameStart = 1;
  - RGB stays 010 for 640 clocks, then 000.
- HS timing: HS falls exactly 658 clocks after each line start (656 + 2 pipeline) and stays low for 96 clocks. Line period = 800.
- VS timing: VS low for exactly 1600 clocks, starting at line 490 + 2 clocks. Frame period = 420000.
- Address scan: oReadAddress steps 0,1,2… every 10 clocks on line 0. It repeats for lines 0–9. Line 10 starts at {row 1, col 0} = 64.
- Cell (3,5) = 3'b100, all others 000: red only for pins in pixel x 50..59, y 30..39.
- Reset low asserted at line 200 mid-line: outputs drop to reset values within the same clock. After release the scan restarts at address 0 with oFrameStart 2 clocks later.

Source files
------------

// File: rtl/vga_frame_reader_pkg.sv
// Shared definitions for the VGA framebuffer reader: default 640x480@60 timing,
// cell colour encodings and RGB bit positions.
package vga_frame_reader_pkg;

    // Default 640x480@60 Hz timing, one pixel per clock
    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    // Cell colour encodings as stored in the framebuffer
    localparam logic [2:0] COLOR_BLACK   = 3'b000;
    localparam logic [2:0] COLOR_BLUE    = 3'b001;
    localparam logic [2:0] COLOR_GREEN   = 3'b010;
    localparam logic [2:0] COLOR_RED     = 3'b100;
    localparam logic [2:0] COLOR_MAGENTA = 3'b101;

    // Bit positions of each gun inside a cell colour
    localparam int unsigned RGB_R_BIT = 2;
    localparam int unsigned RGB_G_BIT = 1;
    localparam int unsigned RGB_B_BIT = 0;

    // Sideband flags that travel alongside the pixel through the pipeline
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic visible;
        logic frame_start;
    } pipe_flags_t;

    localparam pipe_flags_t FLAGS_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, visible: 1'b0,
                                           frame_start: 1'b0};

    // Counter width able to hold 0..n-1
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// Framebuffer read port: registered address out, cell colour back one clock later.
interface vga_frame_reader_if #(
    parameter int unsigned ADDR_BITS = 12
);
    logic [ADDR_BITS-1:0] oReadAddress;
    logic [2:0]           iReadData;

    modport master (
        output oReadAddress,
        input  iReadData
    );

    modport slave (
        input  oReadAddress,
        output iReadData
    );
endinterface

// File: rtl/vga_timing_counter.sv
// One axis of VGA timing: free-running count with decoded sync level,
// visible flag and a wrap pulse for cascading into the next axis.
module vga_timing_counter #(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned VISIBLE    = 640,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_END   = 752,
    parameter int unsigned WIDTH      = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             sync_n_o,
    output logic             visible_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             at_last;

    // Next count plus phase decode of the current count
    always_comb begin
        at_last   = (count_q == WIDTH'(TOTAL - 1));
        wrap_o    = en_i && at_last;
        count_d   = count_q;
        if (en_i) begin
            count_d = at_last ? '0 : count_q + 1'b1;
        end
        sync_n_o  = !((count_q >= WIDTH'(SYNC_START)) && (count_q < WIDTH'(SYNC_END)));
        visible_o = (count_q < WIDTH'(VISIBLE));
        count_o   = count_q;
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_frame_reader.sv
// Scans the cell framebuffer in raster order, enlarging each cell to a
// CELL_SIZE x CELL_SIZE block, and drives 640x480@60 VGA pins through a
// two-stage pipeline (address, then data + delayed sync/visible).
module vga_frame_reader
    import vga_frame_reader_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter int unsigned CELL_SIZE = 10,
    parameter int unsigned COL_BITS  = 6,
    parameter int unsigned ROW_BITS  = 6
) (
    input  logic                      Clock,
    input  logic                      Reset,
    vga_frame_reader_if.master        fb_io,
    output logic                      oVGA_R,
    output logic                      oVGA_G,
    output logic                      oVGA_B,
    output logic                      oVGA_HS,
    output logic                      oVGA_VS,
    output logic                      oFrameStart
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_W     = cnt_width(H_TOTAL);
    localparam int unsigned V_W     = cnt_width(V_TOTAL);
    localparam int unsigned SUB_W   = cnt_width(CELL_SIZE);

    logic [H_W-1:0] h_count;
    logic [V_W-1:0] v_count;
    logic           h_sync_n, h_vis, h_wrap;
    logic           v_sync_n, v_vis, v_wrap;

    vga_timing_counter #(
        .TOTAL      (H_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_VISIBLE + H_FRONT),
        .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC),
        .WIDTH      (H_W)
    ) u_h_counter (
        .clk_i     (Clock),
        .rst_ni    (Reset),
        .en_i      (1'b1),
        .count_o   (h_count),
        .sync_n_o  (h_sync_n),
        .visible_o (h_vis),
        .wrap_o    (h_wrap)
    );

    vga_timing_counter #(
        .TOTAL      (V_TOTAL),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_VISIBLE + V_FRONT),
        .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC),
        .WIDTH      (V_W)
    ) u_v_counter (
        .clk_i     (Clock),
        .rst_ni    (Reset),
        .en_i      (h_wrap),
        .count_o   (v_count),
        .sync_n_o  (v_sync_n),
        .visible_o (v_vis),
        .wrap_o    (v_wrap)
    );

    logic [SUB_W-1:0]    hsub_q, hsub_d, vsub_q, vsub_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;

    // Cell sub-counters: step col every CELL_SIZE visible pixels, row every
    // CELL_SIZE visible lines; line end clears the column side, frame end all
    always_comb begin
        hsub_d = hsub_q;
        col_d  = col_q;
        vsub_d = vsub_q;
        row_d  = row_q;
        if (h_wrap) begin
            hsub_d = '0;
            col_d  = '0;
        end else if (h_vis) begin
            if (hsub_q == SUB_W'(CELL_SIZE - 1)) begin
                hsub_d = '0;
                col_d  = col_q + 1'b1;
            end else begin
                hsub_d = hsub_q + 1'b1;
            end
        end
        if (v_wrap) begin
            vsub_d = '0;
            row_d  = '0;
        end else if (h_wrap && v_vis) begin
            if (vsub_q == SUB_W'(CELL_SIZE - 1)) begin
                vsub_d = '0;
                row_d  = row_q + 1'b1;
            end else begin
                vsub_d = vsub_q + 1'b1;
            end
        end
    end

    // Cell sub-counter registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hsub_q <= '0;
            col_q  <= '0;
            vsub_q <= '0;
            row_q  <= '0;
        end else begin
            hsub_q <= hsub_d;
            col_q  <= col_d;
            vsub_q <= vsub_d;
            row_q  <= row_d;
        end
    end

    pipe_flags_t                  flags_s0, flags_s1_q, flags_s2_q;
    logic [ROW_BITS+COL_BITS-1:0] addr_q;
    logic [2:0]                   rgb_q;

    // Flags for the pixel currently addressed by the counters
    always_comb begin
        flags_s0.hs_n        = h_sync_n;
        flags_s0.vs_n        = v_sync_n;
        flags_s0.visible     = h_vis && v_vis;
        flags_s0.frame_start = (h_count == '0) && (v_count == '0);
    end

    // Stage 1: read address (held through blanking) and flags
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            addr_q     <= '0;
            flags_s1_q <= FLAGS_IDLE;
        end else begin
            if (flags_s0.visible) begin
                addr_q <= {row_q, col_q};
            end
            flags_s1_q <= flags_s0;
        end
    end

    // Stage 2: capture RAM colour, blanked outside the visible region
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rgb_q      <= COLOR_BLACK;
            flags_s2_q <= FLAGS_IDLE;
        end else begin
            rgb_q      <= flags_s1_q.visible ? fb_io.iReadData : COLOR_BLACK;
            flags_s2_q <= flags_s1_q;
        end
    end

    assign fb_io.oReadAddress = addr_q;
    assign oVGA_R             = rgb_q[RGB_R_BIT];
    assign oVGA_G             = rgb_q[RGB_G_BIT];
    assign oVGA_B             = rgb_q[RGB_B_BIT];
    assign oVGA_HS            = flags_s2_q.hs_n;
    assign oVGA_VS            = flags_s2_q.vs_n;
    assign oFrameStart        = flags_s2_q.frame_start;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench: a reference process pushes the expected pin state for
// every clock into queues; a monitor on the falling edge pops and compares.
// DUT A uses default timing; DUT B shortens the frame to 47 lines so the
// vsync pulse and frame period can be observed in a short run.
module tb_vga_frame_reader;
    import vga_frame_reader_pkg::*;

    localparam int B_LINES = 47;           // 40 + 2 + 2 + 3
    localparam int B_FRAME = B_LINES * 800;

    logic Clock = 1'b0;
    logic Reset;

    always #20 Clock = ~Clock;

    vga_frame_reader_if #(.ADDR_BITS(12)) fb_a ();
    vga_frame_reader_if #(.ADDR_BITS(12)) fb_b ();

    // Framebuffer model: colour follows the registered read address
    logic [2:0] mem [4096];
    assign fb_a.iReadData = mem[fb_a.oReadAddress];
    assign fb_b.iReadData = COLOR_BLACK;

    logic a_r, a_g, a_b, a_hs, a_vs, a_fs;
    logic b_r, b_g, b_b, b_hs, b_vs, b_fs;

    vga_frame_reader u_dut_a (
        .Clock       (Clock),
        .Reset       (Reset),
        .fb_io       (fb_a),
        .oVGA_R      (a_r),
        .oVGA_G      (a_g),
        .oVGA_B      (a_b),
        .oVGA_HS     (a_hs),
        .oVGA_VS     (a_vs),
        .oFrameStart (a_fs)
    );

    vga_frame_reader #(
        .V_VISIBLE (40),
        .V_FRONT   (2),
        .V_SYNC    (2),
        .V_BACK    (3)
    ) u_dut_b (
        .Clock       (Clock),
        .Reset       (Reset),
        .fb_io       (fb_b),
        .oVGA_R      (b_r),
        .oVGA_G      (b_g),
        .oVGA_B      (b_b),
        .oVGA_HS     (b_hs),
        .oVGA_VS     (b_vs),
        .oFrameStart (b_fs)
    );

    typedef struct packed {
        logic [2:0]  rgb;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] addr;
    } exp_a_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic fs;
    } exp_b_t;

    exp_a_t q_a[$];
    exp_b_t q_b[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  run      = 1'b0;
    bit  green_lines = 1'b0;   // lines 0..1 come from an all-green framebuffer
    int  k        = 0;         // rising edges since reset release
    int  exp_addr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    function automatic logic [2:0] cell_color(input int x, input int y, input bit green);
        if (green && y < 2) return COLOR_GREEN;
        if (x >= 50 && x < 60 && y >= 30 && y < 40) return COLOR_RED;
        if (x >= 630 && x < 640 && y >= 40 && y < 50) return COLOR_MAGENTA;
        return COLOR_BLACK;
    endfunction

    // Reference: expected pins after each rising edge (pixel on pins = k-2)
    always @(posedge Clock) begin
        if (run) begin : ref_model
            int p, q, h, v, hq, vq, vb;
            exp_a_t ea;
            exp_b_t eb;
            k = k + 1;
            p = k - 2;
            q = k - 1;
            hq = q % 800;
            vq = q / 800;
            if (hq < 640 && vq < 480) exp_addr = (vq / 10) * 64 + hq / 10;
            ea.addr = 12'(exp_addr);
            if (p < 0) begin
                ea.rgb = 3'b000; ea.hs = 1'b1; ea.vs = 1'b1; ea.fs = 1'b0;
                eb = '{hs: 1'b1, vs: 1'b1, fs: 1'b0};
            end else begin
                h  = p % 800;
                v  = (p / 800) % 525;
                vb = (p / 800) % B_LINES;
                ea.rgb = (h < 640 && v < 480) ? cell_color(h, v, green_lines) : 3'b000;
                ea.hs  = !(h >= 656 && h < 752);
                ea.vs  = !(v >= 490 && v < 492);
                ea.fs  = (p % 420000 == 0);
                eb.hs  = ea.hs;
                eb.vs  = !(vb >= 42 && vb < 44);
                eb.fs  = (p % B_FRAME == 0);
            end
            q_a.push_back(ea);
            q_b.push_back(eb);
        end
    end

    // Monitor: compare DUT pins against queued expectations on the falling edge
    always @(negedge Clock) begin
        if (q_a.size() > 0) begin : mon_a
            exp_a_t ea;
            ea = q_a.pop_front();
            check("pins_a", 32'({a_r, a_g, a_b, a_hs, a_vs, a_fs, fb_a.oReadAddress}), 32'(ea));
        end
        if (q_b.size() > 0) begin : mon_b
            exp_b_t eb;
            eb = q_b.pop_front();
            check("sync_b", 32'({b_hs, b_vs, b_fs}), 32'(eb));
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = COLOR_GREEN;
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        check("rst_rgb", 32'({a_r, a_g, a_b}), 32'(0));
        check("rst_hs", 32'(a_hs), 32'(1));
        check("rst_vs", 32'(a_vs), 32'(1));
        check("rst_fs", 32'(a_fs), 32'(0));
        check("rst_addr", 32'(fb_a.oReadAddress), 32'(0));
        check("rst_vs_b", 32'(b_vs), 32'(1));

        // First run: green lines 0..1, then red cell (3,5) and magenta cell (4,63)
        green_lines = 1'b1;
        k = 0;
        exp_addr = 0;
        run = 1'b1;
        Reset = 1'b1;
        repeat (1500) @(negedge Clock);
        for (int i = 0; i < 4096; i++) mem[i] = COLOR_BLACK;
        mem[3 * 64 + 5]  = COLOR_RED;
        mem[4 * 64 + 63] = COLOR_MAGENTA;

        // Stop at line 47, h = 700 on the pins: inside hsync
        repeat (47 * 800 + 702 - 1500) @(negedge Clock);
        #2;
        run = 1'b0;
        check("pre_rst_hs", 32'(a_hs), 32'(0));
        check("pre_rst_addr", 32'(fb_a.oReadAddress), 32'(4 * 64 + 63));
        Reset = 1'b0;
        #1;
        check("mid_rst_hs", 32'(a_hs), 32'(1));
        check("mid_rst_vs", 32'(a_vs), 32'(1));
        check("mid_rst_rgb", 32'({a_r, a_g, a_b}), 32'(0));
        check("mid_rst_fs", 32'(a_fs), 32'(0));
        check("mid_rst_addr", 32'(fb_a.oReadAddress), 32'(0));
        check("mid_rst_hs_b", 32'(b_hs), 32'(1));
        q_a.delete();
        q_b.delete();

        // Second run from a fresh frame with the red/magenta framebuffer
        repeat (3) @(negedge Clock);
        green_lines = 1'b0;
        k = 0;
        exp_addr = 0;
        run = 1'b1;
        Reset = 1'b1;
        repeat (1700) @(negedge Clock);
        #2;
        run = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
